clause_stream_loader: RTL



---
 rtl/clause_stream_loader_pkg.sv | 43 ++++
 rtl/clause_stream_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/clause_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// clause_stream_loader_pkg
//   Shared definitions for the clause-register load path.
//   - Default parameter values and the derived clause-word width (W) and
//     clause-slot count (N) at those defaults.
//   - FSM state encoding for the loader.
//   - Helpers for the derived sizes and for the clause-word field layout:
//     coefficient i sits at bit offset i*C, the bias at offset 2**V*C.
// -----------------------------------------------------------------------------
package clause_stream_loader_pkg;

    localparam int DEF_COEFF_BITS      = 8;
    localparam int DEF_VAR_IDX_BITS    = 2;
    localparam int DEF_CLAUSE_IDX_BITS = 3;

    localparam int W = ((2 ** DEF_VAR_IDX_BITS) + 1) * DEF_COEFF_BITS;
    localparam int N = 2 ** DEF_CLAUSE_IDX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One coefficient per variable plus the bias, each c bits wide.
    function automatic int clause_word_width(input int c, input int v);
        return ((2 ** v) + 1) * c;
    endfunction

    function automatic int clause_slots(input int k);
        return 2 ** k;
    endfunction

    function automatic int coeff_offset(input int i, input int c);
        return i * c;
    endfunction

    function automatic int bias_offset(input int v, input int c);
        return (2 ** v) * c;
    endfunction

endpackage

// File: rtl/clause_stream_loader.sv
// -----------------------------------------------------------------------------
// clause_stream_loader
//   Writer side of the clause-register load interface. Latches a clause count
//   (saturated to the number of slots), pulls one packed clause word per
//   valid/ready handshake, and presents index + word + write strobe to the
//   clause-register bank one cycle after each accept. Builds the reduce-enable
//   mask so only loaded slots feed the reduction tree.
//
// Ports
//   in_clk                  clock, rising edge
//   in_reset                asynchronous active-low reset
//   in_start                begin a load (sampled only in IDLE)
//   in_clause_count         clauses to load, 0..N (larger values saturate)
//   in_coeff_valid          upstream word valid
//   in_coeff_data           packed clause word, bias in the top field
//   out_coeff_ready         registered ready toward upstream
//   out_clause_coefficients word to the clause registers
//   out_clause_index        target slot
//   out_clause_write        write strobe qualifying index/coefficients
//   out_reduce_enable       bit i set when slot i holds a loaded clause
//   out_busy                load in progress (LOAD, FLUSH, DONE)
//   out_done                one-cycle completion pulse
// -----------------------------------------------------------------------------
module clause_stream_loader
    import clause_stream_loader_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = DEF_COEFF_BITS,
    parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = DEF_VAR_IDX_BITS,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = DEF_CLAUSE_IDX_BITS,
    localparam int CW = clause_word_width(MAXIMUM_BIT_WIDTH_OF_COEFFICIENT,
                                          MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX),
    localparam int CI = MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int NS = clause_slots(MAX_BIT_WIDTH_OF_CLAUSES_INDEX)
) (
    input  logic          in_clk,
    input  logic          in_reset,
    input  logic          in_start,
    input  logic [CI:0]   in_clause_count,
    input  logic          in_coeff_valid,
    input  logic [CW-1:0] in_coeff_data,
    output logic          out_coeff_ready,
    output logic [CW-1:0] out_clause_coefficients,
    output logic [CI-1:0] out_clause_index,
    output logic          out_clause_write,
    output logic [NS-1:0] out_reduce_enable,
    output logic          out_busy,
    output logic          out_done
);

    state_t        r_state;
    state_t        w_state_next;

    logic [CI:0]   r_target;
    logic [CI:0]   r_accepted;
    logic          r_ready;
    logic          r_write;
    logic [CW-1:0] r_coeff;
    logic [CI-1:0] r_index;
    logic [NS-1:0] r_mask;

    logic [CI:0]   w_target;
    logic [CI:0]   w_accepted_inc;
    logic          w_start;
    logic          w_accept;
    logic          w_last_accept;
    logic [NS-1:0] w_slot_hit;

    // Counts above the slot count load every slot; no error is flagged.
    assign w_target       = (in_clause_count > (CI+1)'(NS)) ? (CI+1)'(NS) : in_clause_count;
    assign w_start        = (r_state == ST_IDLE) & in_start;
    // r_ready is only ever high in LOAD, so an accept implies LOAD.
    assign w_accept       = in_coeff_valid & r_ready;
    assign w_accepted_inc = r_accepted + (CI+1)'(1);
    assign w_last_accept  = w_accept & (w_accepted_inc == r_target);

    // One-hot decode of the slot being written this cycle.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slot_hit
            assign w_slot_hit[gi] = w_accept & (r_accepted[CI-1:0] == CI'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_start) begin
                    w_state_next = (w_target != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (w_last_accept) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        out_busy = (r_state != ST_IDLE);
        out_done = (r_state == ST_DONE);
    end

    assign out_coeff_ready         = r_ready;
    assign out_clause_coefficients = r_coeff;
    assign out_clause_index        = r_index;
    assign out_clause_write        = r_write;
    assign out_reduce_enable       = r_mask;

    // ---------------------------------------------------------------- datapath
    // Ready is registered: it rises when a non-empty load starts and falls on
    // the edge that takes the final word, so upstream never sees a
    // combinational path from its own valid.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_target   <= '0;
            r_accepted <= '0;
            r_ready    <= 1'b0;
            r_write    <= 1'b0;
            r_coeff    <= '0;
            r_index    <= '0;
            r_mask     <= '0;
        end else begin
            r_write <= w_accept;
            if (w_start) begin
                r_target   <= w_target;
                r_accepted <= '0;
                r_mask     <= '0;
                r_ready    <= (w_target != '0);
            end else begin
                // Enable bit appears together with the write strobe for its slot.
                r_mask <= r_mask | w_slot_hit;
                if (w_accept) begin
                    r_coeff    <= in_coeff_data;
                    r_index    <= r_accepted[CI-1:0];
                    r_accepted <= w_accepted_inc;
                    if (w_last_accept) begin
                        r_ready <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
